// File: rtl/jt1942_sndcmd_pkg.sv
// Shared types for the main-CPU to sound-board command path: sender FSM states,
// latch-select encoding and the queued command word layout.
package jt1942_sndcmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_HOLD = 2'd2
  } snd_state_t;

  localparam logic SEL_LATCH0 = 1'b0;
  localparam logic SEL_LATCH1 = 1'b1;

  typedef struct packed {
    logic       sel;
    logic [7:0] data;
  } snd_cmd_t;

endpackage

// File: rtl/jt1942_sndcmd_fifo.sv
// Small command queue of {sel, data} words with push/pop/flush, advancing on cen.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module jt1942_sndcmd_fifo
  import jt1942_sndcmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cen,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  snd_cmd_t din,
  output snd_cmd_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  snd_cmd_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = cen && push && !full && !flush;
  assign do_pop  = cen && pop && !empty && !flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (cen && flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset: an entry is only visible once its pointer has advanced.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jt1942_sndcmd.sv
// Main-CPU side sound command sender: queues latch writes, replays them as spaced
// one-cen3 latch strobes, and generates snd_int and the sound reset line sres_b.
module jt1942_sndcmd
  import jt1942_sndcmd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int HOLD    = 64,
  parameter int INT_PER = 12500,
  parameter int INT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen3,
  input  logic       cpu_wr,
  input  logic       cpu_sel,
  input  logic [7:0] cpu_din,
  input  logic       sres_wr,
  input  logic       sres_din,
  output logic [7:0] main_dout,
  output logic       main_latch0_cs,
  output logic       main_latch1_cs,
  output logic       snd_int,
  output logic       sres_b,
  output logic       full,
  output logic       ovf
);

  localparam int HW  = $clog2(HOLD) + 1;
  localparam int ICW = $clog2(INT_PER);

  snd_state_t     state, state_nx;
  logic [1:0]     cs_q, cs_nx;
  logic [7:0]     dout_nx;
  logic [HW-1:0]  hold_cnt, hold_nx;
  logic [ICW-1:0] int_cnt;
  logic           pop;
  logic           empty;
  snd_cmd_t       fifo_dout;

  jt1942_sndcmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen3),
    .push  (cpu_wr && sres_b),
    .pop   (pop),
    .flush (!sres_b),
    .din   (snd_cmd_t'({cpu_sel, cpu_din})),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cs_q      <= 2'b00;
      main_dout <= 8'h00;
      hold_cnt  <= '0;
    end else if (cen3) begin
      state     <= state_nx;
      cs_q      <= cs_nx;
      main_dout <= dout_nx;
      hold_cnt  <= hold_nx;
    end
  end

  // The hold ends when the counter steps down to zero, so the next strobe lands HOLD+1 ticks later.
  always_comb begin
    state_nx = state;
    cs_nx    = 2'b00;
    dout_nx  = main_dout;
    hold_nx  = hold_cnt;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          dout_nx  = fifo_dout.data;
          cs_nx    = (fifo_dout.sel == SEL_LATCH1) ? 2'b10 : 2'b01;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        hold_nx  = HW'(HOLD - 1);
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        hold_nx = hold_cnt - 1'b1;
        if (hold_cnt < HW'(2)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!sres_b) begin
      state_nx = ST_IDLE;
      cs_nx    = 2'b00;
      pop      = 1'b0;
    end
  end

  // Masking with sres_b drops a strobe in flight the moment the sound side is put in reset.
  assign main_latch0_cs = cs_q[0] & sres_b;
  assign main_latch1_cs = cs_q[1] & sres_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sres_b <= 1'b0;
      ovf    <= 1'b0;
    end else if (cen3) begin
      if (sres_wr) sres_b <= sres_din;
      if (!sres_b)              ovf <= 1'b0;
      else if (cpu_wr && full)  ovf <= 1'b1;
    end
  end

  // snd_int follows the count one tick late so it is low straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_cnt <= '0;
      snd_int <= 1'b0;
    end else if (cen3) begin
      int_cnt <= (int_cnt == ICW'(INT_PER - 1)) ? '0 : int_cnt + 1'b1;
      snd_int <= (int_cnt < ICW'(INT_W));
    end
  end

endmodule

// File: tb/tb_jt1942_sndcmd.sv
// Directed bench for jt1942_sndcmd: interrupt timing, latch strobe delivery and spacing,
// queue full/overflow, sound-reset flush and asynchronous reset.
module tb_jt1942_sndcmd;

  localparam int DEPTH   = 4;
  localparam int H       = 16;
  localparam int INT_PER = 200;
  localparam int INT_W   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen3 = 1'b0;
  logic [1:0] div = 2'd0;
  logic       cpu_wr = 1'b0;
  logic       cpu_sel = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       sres_wr = 1'b0;
  logic       sres_din = 1'b0;
  logic [7:0] main_dout;
  logic       main_latch0_cs, main_latch1_cs;
  logic       snd_int, sres_b, full, ovf;

  int checks = 0;
  int errors = 0;
  logic both_seen = 1'b0;

  jt1942_sndcmd #(.DEPTH(DEPTH), .HOLD(H), .INT_PER(INT_PER), .INT_W(INT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cen3           (cen3),
    .cpu_wr         (cpu_wr),
    .cpu_sel        (cpu_sel),
    .cpu_din        (cpu_din),
    .sres_wr        (sres_wr),
    .sres_din       (sres_din),
    .main_dout      (main_dout),
    .main_latch0_cs (main_latch0_cs),
    .main_latch1_cs (main_latch1_cs),
    .snd_int        (snd_int),
    .sres_b         (sres_b),
    .full           (full),
    .ovf            (ovf)
  );

  always #5 clk = ~clk;

  // cen3 changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    div  <= div + 2'd1;
    cen3 <= (div == 2'd3);
  end

  always @(main_latch0_cs or main_latch1_cs) begin
    if (main_latch0_cs && main_latch1_cs) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic en;
    en = 1'b0;
    while (!en) begin
      @(posedge clk);
      en = cen3;
    end
    #1;
  endtask

  // Steps until a latch strobe is seen; n = -1 when the bound expires.
  task automatic wait_cs(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (main_latch0_cs || main_latch1_cs) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic push(input logic sel, input logic [7:0] d);
    cpu_wr  = 1'b1;
    cpu_sel = sel;
    cpu_din = d;
    step();
    cpu_wr  = 1'b0;
  endtask

  task automatic sres_set(input logic v);
    sres_wr  = 1'b1;
    sres_din = v;
    step();
    sres_wr  = 1'b0;
  endtask

  initial begin
    int n;
    int nrise;
    int rise [4];
    int fall [4];
    logic prev;

    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dout", 32'(main_dout), 32'h00);
    chk("rst_cs", 32'({main_latch1_cs, main_latch0_cs}), 32'h0);
    chk("rst_int_sres", 32'({snd_int, sres_b}), 32'h0);
    chk("rst_full_ovf", 32'({full, ovf}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Interrupt: 3 periods from a fresh reset
    nrise = 0;
    prev  = snd_int;
    for (int i = 1; i <= 3 * INT_PER; i++) begin
      step();
      if (snd_int && !prev) begin
        if (nrise < 4) rise[nrise] = i;
        nrise++;
      end
      if (!snd_int && prev && nrise > 0 && nrise <= 4) fall[nrise-1] = i;
      prev = snd_int;
    end
    chk("int_rises", 32'(nrise), 32'd3);
    chk("int_first", 32'(rise[0]), 32'd1);
    chk("int_per1", 32'(rise[1] - rise[0]), 32'(INT_PER));
    chk("int_per2", 32'(rise[2] - rise[1]), 32'(INT_PER));
    for (int k = 0; k < 3; k++) chk("int_width", 32'(fall[k] - rise[k]), 32'(INT_W));

    // Writes are ignored while the sound side is held in reset
    push(1'b0, 8'hEE);
    wait_cs(2 * H, n);
    chk("sres_low_ignore", 32'(n), 32'hFFFF_FFFF);
    sres_set(1'b1);
    chk("sres_release", 32'(sres_b), 32'h1);
    wait_cs(2 * H, n);
    chk("no_stale_cmd", 32'(n), 32'hFFFF_FFFF);

    // Single command
    push(1'b0, 8'h5A);
    chk("cs_not_at_push", 32'({main_latch1_cs, main_latch0_cs}), 32'h0);
    step();
    chk("cs0_5a", 32'({main_latch1_cs, main_latch0_cs}), 32'h1);
    chk("dout_5a", 32'(main_dout), 32'h5A);

    // Four commands during the 0x5A hold, then a fifth while full
    push(1'b0, 8'h01);
    chk("cs_one_tick", 32'({main_latch1_cs, main_latch0_cs}), 32'h0);
    push(1'b1, 8'h02);
    push(1'b0, 8'h03);
    push(1'b1, 8'h04);
    chk("full_after4", 32'({full, ovf}), 32'h2);
    chk("dout_hold_5a", 32'(main_dout), 32'h5A);
    push(1'b0, 8'h99);
    chk("ovf_full", 32'({full, ovf}), 32'h3);
    wait_cs(4 * H, n);
    chk("space_5a_01", 32'(n), 32'(H + 1 - 5));
    chk("cmd01", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h101);
    chk("full_after_pop", 32'(full), 32'h0);
    wait_cs(4 * H, n);
    chk("space_02", 32'(n), 32'(H + 1));
    chk("cmd02", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h202);
    wait_cs(4 * H, n);
    chk("space_03", 32'(n), 32'(H + 1));
    chk("cmd03", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h103);
    wait_cs(4 * H, n);
    chk("space_04", 32'(n), 32'(H + 1));
    chk("cmd04", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h204);
    chk("ovf_sticky", 32'(ovf), 32'h1);
    wait_cs(3 * H, n);
    chk("dropped_99", 32'(n), 32'hFFFF_FFFF);
    sres_set(1'b0);
    chk("sres_low", 32'(sres_b), 32'h0);
    step();
    chk("ovf_cleared", 32'(ovf), 32'h0);
    sres_set(1'b1);
    chk("after_sres_flags", 32'({sres_b, full, ovf}), 32'h4);
    wait_cs(2 * H, n);
    chk("queue_empty", 32'(n), 32'hFFFF_FFFF);

    // Sound reset during HOLD with two entries queued
    push(1'b0, 8'h10);
    step();
    chk("cmd10", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h110);
    push(1'b1, 8'h20);
    push(1'b0, 8'h30);
    sres_set(1'b0);
    wait_cs(3 * H, n);
    chk("flush_no_cs", 32'(n), 32'hFFFF_FFFF);
    chk("flush_full", 32'(full), 32'h0);
    sres_set(1'b1);
    wait_cs(2 * H, n);
    chk("flush_empty", 32'(n), 32'hFFFF_FFFF);
    push(1'b1, 8'h77);
    step();
    chk("cmd77", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h277);

    // Asynchronous reset while a strobe is high
    push(1'b0, 8'h3C);
    wait_cs(2 * H, n);
    chk("space_3c", 32'(n), 32'(H + 1 - 1));
    chk("cmd3c", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h13C);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cs_dout", 32'({main_latch1_cs, main_latch0_cs, main_dout}), 32'h000);
    chk("arst_flags", 32'({snd_int, sres_b, full, ovf}), 32'h0);
    chk("never_both_cs", 32'(both_seen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
